// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-SRAM port (1-cycle read latency)
// between I-cache refills and D-cache refills/write-backs. One line-sized,
// word-sequential burst runs at a time. Simultaneous requests are resolved
// round-robin against the last granted requester.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_req/i_addr        I-cache refill request and miss byte address
//   i_rvalid/i_rdata    I refill word strobe and data
//   i_done              one-cycle pulse when the I burst completes
//   d_req/d_we/d_addr   D-cache request, 1 = write-back, byte address
//   d_widx/d_wdata      word index asked of the D requester, its word back
//   d_rvalid/d_rdata    D refill word strobe and data
//   d_done              one-cycle pulse when the D burst completes
//   mem_en/mem_we       memory access / write strobe
//   mem_addr/mem_wdata  memory byte address / write data
//   mem_rdata           read data for the access issued the previous cycle
//   busy                arbiter is not idle
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [CNT_W-1:0]  d_widx,
  input  logic [31:0]       d_wdata,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_d_q, grant_d_d;   // 1 = D owns the burst
  logic              last_d_q, last_d_d;     // 1 = D was granted last
  logic              we_lat_q, we_lat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;

  // D wins when alone, or on a tie when I was served last.
  logic              pick_d;
  logic [ADDR_W-1:0] pick_addr;
  assign pick_d    = d_req && (!i_req || !last_d_q);
  assign pick_addr = pick_d ? d_addr : i_addr;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_d_q <= 1'b0;
      last_d_q  <= 1'b0;
      we_lat_q  <= 1'b0;
      base_q    <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_d_q <= grant_d_d;
      last_d_q  <= last_d_d;
      we_lat_q  <= we_lat_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    grant_d_d = grant_d_q;
    last_d_d  = last_d_q;
    we_lat_d  = we_lat_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    rd_pend_d = rd_pend_q;
    unique case (state_q)
      S_IDLE: begin
        rd_pend_d = 1'b0;
        if (i_req || d_req) begin
          grant_d_d = pick_d;
          last_d_d  = pick_d;
          we_lat_d  = pick_d && d_we;
          base_d    = pick_addr & ~LINE_MASK;
          cnt_d     = '0;
          state_d   = S_BURST;
        end
      end
      S_BURST: begin
        cnt_d     = cnt_q + CNT_W'(1);
        // A read issued now returns next cycle.
        rd_pend_d = !we_lat_q;
        if (cnt_q == CNT_LAST) begin
          state_d = we_lat_q ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        rd_pend_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: memory port, requester strobes, zero when unused.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    d_widx    = '0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    i_done    = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_done    = 1'b0;
    busy      = (state_q != S_IDLE);
    if (state_q == S_BURST) begin
      mem_en   = 1'b1;
      mem_we   = we_lat_q;
      mem_addr = base_q + ADDR_W'({cnt_q, 2'b00});
      if (we_lat_q) begin
        d_widx    = cnt_q;
        mem_wdata = d_wdata;
        d_done    = (cnt_q == CNT_LAST);
      end
    end
    if (rd_pend_q) begin
      if (grant_d_q) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end else begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end
    end
    // The final read word lands in DRAIN together with done.
    if (state_q == S_DRAIN) begin
      if (grant_d_q) d_done = 1'b1;
      else           i_done = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against mem_arbiter with an SRAM model,
// a cycle-timeline reference model checked every cycle, and literal checks.
module tb_mem_arbiter;

  localparam int LW   = 4;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr;
  logic        i_rvalid, i_done, d_rvalid, d_done;
  logic [31:0] i_rdata, d_rdata, d_wdata;
  logic [1:0]  d_widx;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] wb_line [LW];

  always #5 clk = ~clk;

  // D requester supplies the write-back word combinationally.
  assign d_wdata = wb_line[d_widx];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_widx(d_widx), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous SRAM, 1-cycle read latency, word index = addr[9:2].
  logic [31:0] sram [256];
  initial begin
    for (int k = 0; k < 256; k++) sram[k] = 32'h5A5A_0000 | (k << 2);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en && !mem_we) mem_rdata = sram[mem_addr[9:2]];
      else if (mem_en && mem_we) sram[mem_addr[9:2]] = mem_wdata;
    end
  end

  // Reference model: each granted burst is laid out as a timeline of
  // expected outputs indexed by absolute cycle number.
  typedef struct {
    bit        busy, en, we, i_rv, d_rv, i_dn, d_dn;
    bit [31:0] addr, wdata, rdata;
    bit [1:0]  widx;
  } exp_t;

  exp_t        et [MAXC];
  exp_t        zero_e;
  logic [31:0] mmem [256];
  int          free_at = 0;
  bit          last_g  = 1'b0;   // 1 = D served last

  // Observation logs for the literal checks.
  logic [31:0] addr_log[$], wd_log[$], rd_log[$];
  int          en_start[$];
  int          rv_first = -1;
  bit          prev_en  = 1'b0;

  task automatic clr_logs();
    addr_log.delete(); wd_log.delete(); rd_log.delete(); en_start.delete();
    rv_first = -1;
  endtask

  initial begin
    exp_t        e;
    bit          gd, wr;
    logic [31:0] base;
    int          c;
    for (int k = 0; k < 256; k++) mmem[k] = 32'h5A5A_0000 | (k << 2);
    forever begin
      @(negedge clk);
      c = cyc;
      if (c + LW + 3 >= MAXC) begin
        $display("FAIL cycle_table at cycle %0d: got overflow want room", c);
        $fatal(1);
      end
      if (rst) begin
        for (int k = c; k < c + LW + 3; k++) et[k] = zero_e;
        free_at = c + 1;
        last_g  = 1'b0;
      end
      e = et[c];
      check("busy",      busy,      e.busy);
      check("mem_en",    mem_en,    e.en);
      check("mem_we",    mem_we,    e.we);
      check("mem_addr",  mem_addr,  e.addr);
      check("mem_wdata", mem_wdata, e.wdata);
      check("d_widx",    d_widx,    e.widx);
      check("i_rvalid",  i_rvalid,  e.i_rv);
      check("i_rdata",   i_rdata,   e.i_rv ? e.rdata : 32'h0);
      check("i_done",    i_done,    e.i_dn);
      check("d_rvalid",  d_rvalid,  e.d_rv);
      check("d_rdata",   d_rdata,   e.d_rv ? e.rdata : 32'h0);
      check("d_done",    d_done,    e.d_dn);
      if (mem_en) addr_log.push_back(mem_addr);
      if (mem_en && !prev_en) en_start.push_back(c);
      prev_en = mem_en;
      if (mem_we) wd_log.push_back(mem_wdata);
      if (i_rvalid) rd_log.push_back(i_rdata);
      if (d_rvalid) rd_log.push_back(d_rdata);
      if ((i_rvalid || d_rvalid) && rv_first < 0) rv_first = c;
      if (!rst) begin
        if (e.en && e.we)  mmem[e.addr[9:2]] = e.wdata;
        if (e.en && !e.we) et[c + 1].rdata = mmem[e.addr[9:2]];
        if (c >= free_at && (i_req || d_req)) begin
          gd     = d_req && (!i_req || !last_g);
          last_g = gd;
          wr     = gd && d_we;
          base   = (gd ? d_addr : i_addr) & ~(32'(LW * 4) - 32'd1);
          for (int k = 0; k < LW; k++) begin
            et[c + 1 + k].busy = 1'b1;
            et[c + 1 + k].en   = 1'b1;
            et[c + 1 + k].we   = wr;
            et[c + 1 + k].addr = base + 32'(4 * k);
            if (wr) begin
              et[c + 1 + k].wdata = wb_line[k];
              et[c + 1 + k].widx  = 2'(k);
            end
          end
          if (wr) begin
            et[c + LW].d_dn = 1'b1;
            free_at = c + LW + 1;
          end else begin
            for (int k = 0; k < LW; k++) begin
              if (gd) et[c + 2 + k].d_rv = 1'b1;
              else    et[c + 2 + k].i_rv = 1'b1;
            end
            et[c + LW + 1].busy = 1'b1;
            if (gd) et[c + LW + 1].d_dn = 1'b1;
            else    et[c + LW + 1].i_dn = 1'b1;
            free_at = c + LW + 2;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit who, output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (who ? d_done : i_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout who=%0d at cycle %0d: got none want pulse", who, cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got no finish want finish", cyc);
    $fatal(1);
  end

  initial begin
    int          t0, td, ti, n;
    bit          who [3];
    logic [31:0] aw [LW];
    logic [31:0] bw [LW];
    aw = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    bw = '{32'hB0B0_0B0B, 32'hB1B1_1B1B, 32'hB2B2_2B2B, 32'hB3B3_3B3B};
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0;
    for (int k = 0; k < LW; k++) wb_line[k] = '0;
    repeat (3) step();
    rst = 0;
    step();
    check("busy_after_reset", busy, 0);

    // I refill of a line-internal address.
    clr_logs(); i_addr = 32'h0000_004C; i_req = 1; t0 = cyc;
    wait_done(1'b0, td); step(); i_req = 0;
    check("t1_done_cycle", td, t0 + 5);
    check("t1_rvalid_first", rv_first, t0 + 2);
    check("t1_n_addr", addr_log.size(), LW);
    for (int k = 0; k < LW; k++) check("t1_addr", addr_log[k], 32'h40 + 4 * k);
    for (int k = 0; k < LW; k++) check("t1_rdata", rd_log[k], 32'h5A5A_0040 + 4 * k);

    // D write-back, then read it back through a refill.
    step();
    clr_logs(); for (int k = 0; k < LW; k++) wb_line[k] = aw[k];
    d_we = 1; d_addr = 32'h9000; d_req = 1; t0 = cyc;
    wait_done(1'b1, td); step(); d_req = 0; d_we = 0;
    check("t2_done_cycle", td, t0 + 4);
    for (int k = 0; k < LW; k++) check("t2_addr", addr_log[k], 32'h9000 + 4 * k);
    for (int k = 0; k < LW; k++) check("t2_wdata", wd_log[k], aw[k]);
    step();
    clr_logs(); d_addr = 32'h9004; d_req = 1;
    wait_done(1'b1, td); step(); d_req = 0;
    for (int k = 0; k < LW; k++) check("t2_readback", rd_log[k], aw[k]);

    // Tie in the first cycle after reset: D first, I two cycles after d_done.
    rst = 1; step(); step();
    clr_logs(); rst = 0; i_addr = 32'h300; d_addr = 32'h100; d_we = 0; i_req = 1; d_req = 1;
    wait_done(1'b1, td); step(); d_req = 0;
    wait_done(1'b0, ti); step(); i_req = 0;
    check("t3_d_first", addr_log[0], 32'h100);
    check("t3_i_start", en_start[1], td + 2);
    check("t3_i_addr", addr_log[4], 32'h300);
    // After a lone D burst the last grant is D, so the next tie goes to I.
    step(); d_addr = 32'h180; d_req = 1;
    wait_done(1'b1, td); step(); d_req = 0;
    step();
    clr_logs(); i_addr = 32'h40; d_addr = 32'h100; i_req = 1; d_req = 1;
    wait_done(1'b0, ti); step(); i_req = 0;
    wait_done(1'b1, td); step(); d_req = 0;
    check("t3_pair2_i_first", addr_log[0], 32'h40);
    check("t3_pair2_d_second", addr_log[4], 32'h100);
    check("t3_pair2_order", ti < td, 1);

    // Both held continuously after reset: grants alternate D, I, D.
    rst = 1; step(); rst = 0; step();
    i_addr = 32'h80; d_addr = 32'h9000; d_we = 0; i_req = 1; d_req = 1;
    n = 0;
    for (int c = 0; c < 80 && n < 3; c++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        who[n] = d_done;
        n++;
      end
    end
    step(); i_req = 0; d_req = 0;
    check("t4_n_bursts", n, 3);
    check("t4_grant0", who[0], 1);
    check("t4_grant1", who[1], 0);
    check("t4_grant2", who[2], 1);

    // Reset while a D write-back is at word 2.
    step(); clr_logs();
    for (int k = 0; k < LW; k++) wb_line[k] = bw[k];
    d_we = 1; d_addr = 32'h200; d_req = 1;
    step(); step(); step();
    check("t5_widx_before_reset", d_widx, 2);
    rst = 1; #1;
    check("t5_busy", busy, 0);
    check("t5_mem_en", mem_en, 0);
    check("t5_mem_we", mem_we, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_wdata", mem_wdata, 0);
    check("t5_d_widx", d_widx, 0);
    check("t5_d_done", d_done, 0);
    d_we = 0; i_addr = 32'h340; i_req = 1;
    step(); step(); rst = 0;
    clr_logs();
    wait_done(1'b1, td); step(); d_req = 0;
    wait_done(1'b0, ti); step(); i_req = 0;
    check("t5_d_first", addr_log[0], 32'h200);
    check("t5_partial0", rd_log[0], bw[0]);
    check("t5_partial1", rd_log[1], bw[1]);
    check("t5_untouched2", rd_log[2], 32'h5A5A_0208);
    check("t5_untouched3", rd_log[3], 32'h5A5A_020C);

    // Line at the top of the address space.
    step(); clr_logs(); d_addr = 32'hFFFF_FFF4; d_req = 1;
    wait_done(1'b1, td); step(); d_req = 0;
    check("t6_n_addr", addr_log.size(), LW);
    for (int k = 0; k < LW; k++) check("t6_addr", addr_log[k], 32'hFFFF_FFF0 + 4 * k);
    for (int k = 0; k < LW; k++) check("t6_rdata", rd_log[k], 32'h5A5A_03F0 + 4 * k);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
